hazard_sequencer: RTL
=====================

Name: hazard_sequencer

Overview:
- Central pipeline controller for the 5-stage RV32I core.
- Drives the stall/flush enables of the F/D, D/E, E/M and M/W pipeline registers, and the E-stage operand forwarding selects.
- Sequences three things:
  - post-reset bubble insertion;
  - load-use stalls and taken-branch/jump flushes;
  - multi-cycle data-memory waits, with timeout detection and performance counters.

Parameters:
INIT_CYCLES, 3, cycles of forced bubbles after reset release (>=1)
TIMEOUT, 64, max consecutive memory-wait cycles before timeout (>=2)
CNT_WIDTH, 32, width of performance counters

Ports:
clk  in  1  clock, rising-edge
rst_n  in  1  asynchronous active-low reset
Rs1D, Rs2D  in  5 each  source registers in Decode
Rs1E, Rs2E, RdE  in  5 each  source/dest registers in Execute
RdM, RdW  in  5 each  dest registers in Memory/Writeback
RegWriteM, RegWriteW  in  1 each  register-write enables in M/W
ResultSrcE  in  1  Execute instruction is a load
PCSrcE  in  1  taken branch or jump resolved in Execute
MemReqM  in  1  Memory-stage load/store access valid
mem_ready  in  1  data memory completes access this cycle
ForwardAE, ForwardBE  out  2 each  00 regfile, 10 from ALUResultM, 01 from ResultW
StallF, StallD, StallE, StallM  out  1 each  hold the corresponding pipeline register
FlushD, FlushE, FlushM, FlushW  out  1 each  load a bubble into the register
mem_timeout  out  1  sticky error flag
stall_cnt, flush_cnt  out  CNT_WIDTH each  performance counters

Behaviour:
- States: INIT, RUN, MEM_WAIT. Reset (async, rst_n=0) forces:
  - state=INIT, init counter=0, wait counter=0;
  - mem_timeout=0, stall_cnt=0, flush_cnt=0;
  - all outputs are combinational from state and inputs. While rst_n=0 they read: StallF=1, FlushD=FlushE=FlushM=FlushW=1, other stalls 0, ForwardAE=ForwardBE=00.
- INIT:
  - outputs StallF=1, FlushD=FlushE=FlushM=FlushW=1; all other inputs are ignored.
  - init counter increments each cycle; after INIT_CYCLES cycles in INIT, go to RUN.
- Forwarding (all states, combinational):
  - ForwardAE=10 if RegWriteM && RdM!=0 && RdM==Rs1E;
  - else 01 if RegWriteW && RdW!=0 && RdW==Rs1E;
  - else 00. ForwardBE is the same rule using Rs2E. M has priority over W.
- memwait = MemReqM && !mem_ready. It applies in RUN and MEM_WAIT, and has highest priority:
  - StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=FlushM=0;
  - the PCSrcE and load-use rules are suppressed (the E instruction is frozen and is re-evaluated after the wait).
- Taken branch (no memwait): PCSrcE=1 -> FlushD=FlushE=1, no stalls. Branch wins over a simultaneous load-use, because the D instruction is wrong-path.
- Load-use (no memwait, PCSrcE=0): ResultSrcE && RdE!=0 && (RdE==Rs1D || RdE==Rs2D) -> StallF=StallD=1, FlushE=1.
- Otherwise all stall/flush outputs are 0.
- Transitions:
  - RUN -> MEM_WAIT when memwait.
  - MEM_WAIT -> RUN when mem_ready=1 or MemReqM=0.
  - In MEM_WAIT the wait counter increments each cycle; it clears on entering RUN.
  - When the wait counter reaches TIMEOUT-1 while memwait is still true: set mem_timeout=1 (sticky until reset), force return to RUN next cycle, and assert FlushM=1 for that cycle to drop the access.
- stall_cnt:
  - +1 in every RUN/MEM_WAIT cycle where StallF=1;
  - saturates at all-ones; does not count in INIT.
- flush_cnt:
  - +1 in every RUN cycle where PCSrcE caused a flush;
  - saturates; does not count in INIT.
- Reset asserted mid-wait or mid-stall: immediate return to INIT; counters and mem_timeout clear.

Test Plan:
1. Reset released, INIT_CYCLES=3 -> FlushD/E/M/W and StallF high for exactly 3 cycles, then all 0 in RUN; counters 0.
2. RegWriteM=1, RdM=5, Rs1E=5; RegWriteW=1, RdW=5, Rs2E=5 -> ForwardAE=10, ForwardBE=01. Then RdM=0, Rs1E=0 -> ForwardAE=00.
3. Load-use: ResultSrcE=1, RdE=7, Rs2D=7, PCSrcE=0 -> StallF=StallD=FlushE=1 for one cycle, stall_cnt +1. The same cycle with PCSrcE=1 -> FlushD=FlushE=1, StallF=0, flush_cnt +1.
4. MemReqM=1, mem_ready=0 for 4 cycles then 1 -> StallF..StallM=1, FlushW=1 for 4 cycles. State returns to RUN; stall_cnt +4; mem_timeout stays 0.
5. TIMEOUT=64, mem_ready held 0 -> on wait cycle 64: mem_timeout=1, FlushM=1, state RUN next cycle. mem_timeout stays 1 until rst_n=0.
6. rst_n pulled low during MEM_WAIT -> outputs immediately take reset values, and state re-enters INIT with counters cleared.

Source files
------------

// File: rtl/hazard_sequencer.sv
// Pipeline hazard controller for a 5-stage RV32I core: post-reset bubbles, forwarding,
// load-use stalls, branch flushes and data-memory wait sequencing with timeout detection.
module hazard_sequencer #(
    parameter int unsigned INIT_CYCLES = 3,
    parameter int unsigned TIMEOUT     = 64,
    parameter int unsigned CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [4:0]           Rs1D,
    input  logic [4:0]           Rs2D,
    input  logic [4:0]           Rs1E,
    input  logic [4:0]           Rs2E,
    input  logic [4:0]           RdE,
    input  logic [4:0]           RdM,
    input  logic [4:0]           RdW,
    input  logic                 RegWriteM,
    input  logic                 RegWriteW,
    input  logic                 ResultSrcE,
    input  logic                 PCSrcE,
    input  logic                 MemReqM,
    input  logic                 mem_ready,
    output logic [1:0]           ForwardAE,
    output logic [1:0]           ForwardBE,
    output logic                 StallF,
    output logic                 StallD,
    output logic                 StallE,
    output logic                 StallM,
    output logic                 FlushD,
    output logic                 FlushE,
    output logic                 FlushM,
    output logic                 FlushW,
    output logic                 mem_timeout,
    output logic [CNT_WIDTH-1:0] stall_cnt,
    output logic [CNT_WIDTH-1:0] flush_cnt
);

    localparam int unsigned InitW = (INIT_CYCLES < 2) ? 1 : $clog2(INIT_CYCLES + 1);
    localparam int unsigned WaitW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        StInit,
        StRun,
        StMemWait
    } state_e;

    state_e               state_q, state_d;
    logic [InitW-1:0]     init_cnt_q, init_cnt_d;
    logic [WaitW-1:0]     wait_cnt_q, wait_cnt_d;
    logic                 mem_timeout_q, mem_timeout_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

    logic memwait;
    logic load_use;
    logic wait_expired;

    assign memwait      = MemReqM & ~mem_ready;
    assign load_use     = ResultSrcE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
    assign wait_expired = (wait_cnt_q == WaitW'(TIMEOUT - 1));

    always_comb begin
        state_d       = state_q;
        init_cnt_d    = init_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        stall_cnt_d   = stall_cnt_q;
        flush_cnt_d   = flush_cnt_q;
        ForwardAE     = 2'b00;
        ForwardBE     = 2'b00;
        StallF        = 1'b0;
        StallD        = 1'b0;
        StallE        = 1'b0;
        StallM        = 1'b0;
        FlushD        = 1'b0;
        FlushE        = 1'b0;
        FlushM        = 1'b0;
        FlushW        = 1'b0;

        // Forwarding stays at regfile while the pipeline is being filled with bubbles.
        if (state_q != StInit) begin
            if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E)) begin
                ForwardAE = 2'b10;
            end else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E)) begin
                ForwardAE = 2'b01;
            end
            if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E)) begin
                ForwardBE = 2'b10;
            end else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E)) begin
                ForwardBE = 2'b01;
            end
        end

        case (state_q)
            StInit: begin
                StallF = 1'b1;
                FlushD = 1'b1;
                FlushE = 1'b1;
                FlushM = 1'b1;
                FlushW = 1'b1;
                if (init_cnt_q == InitW'(INIT_CYCLES - 1)) begin
                    state_d    = StRun;
                    init_cnt_d = '0;
                end else begin
                    init_cnt_d = init_cnt_q + 1'b1;
                end
            end
            StRun, StMemWait: begin
                if (memwait) begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    StallE = 1'b1;
                    StallM = 1'b1;
                    FlushW = 1'b1;
                    if (wait_expired) begin
                        // Abandon the access: drop it from M and resume normal sequencing.
                        FlushM        = 1'b1;
                        mem_timeout_d = 1'b1;
                        state_d       = StRun;
                        wait_cnt_d    = '0;
                    end else begin
                        state_d    = StMemWait;
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                end else begin
                    state_d    = StRun;
                    wait_cnt_d = '0;
                    if (PCSrcE) begin
                        FlushD = 1'b1;
                        FlushE = 1'b1;
                        if (state_q == StRun && flush_cnt_q != '1) begin
                            flush_cnt_d = flush_cnt_q + 1'b1;
                        end
                    end else if (load_use) begin
                        StallF = 1'b1;
                        StallD = 1'b1;
                        FlushE = 1'b1;
                    end
                end
                if (StallF && stall_cnt_q != '1) begin
                    stall_cnt_d = stall_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StInit;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StInit;
            init_cnt_q    <= '0;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            init_cnt_q    <= init_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
        end
    end

    assign mem_timeout = mem_timeout_q;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;

endmodule
